uart_ctrl: RTL and testbench

- Sequences every access to the UART peripheral on the CPU I/O bus.
- Buffers CPU transmit bytes in a small FIFO and drains it to the UART data port only after a status poll reports TX ready.
- Serves CPU status and data reads with priority over draining.
- Sits between the CPU I/O decode and the uart block; owns sel_data, sel_status, rnw and the bus output enable.

---
 rtl/uart_ctrl_pkg.sv | 24 ++
 rtl/uart_ctrl_if.sv | 29 ++
 rtl/uart_ctrl_sync_fifo.sv | 69 ++++++
 rtl/uart_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg
// Shared definitions for the UART access controller:
//   - ctrl_state_t : controller FSM states (IDLE, RD, POLL, TX)
//   - RX_AVAIL / TX_READY : bit positions inside the UART status byte
//   - gap_width()  : width of the post-poll back-off counter
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_POLL = 2'd2,
      ST_TX   = 2'd3
   } ctrl_state_t;

   localparam int RX_AVAIL = 0;
   localparam int TX_READY = 1;

   // The back-off counter is loaded with gap-1 (see uart_ctrl), so it only
   // ever needs to hold values up to gap-1.
   function automatic int gap_width(input int gap);
      return (gap > 1) ? $clog2(gap) : 1;
   endfunction

endpackage

// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if
// Controller-to-UART register bus, one access per cycle.
//   sel_data   : UART data port select
//   sel_status : UART status port select
//   rnw        : 1 = read, 0 = write
//   bus_out    : byte driven toward the UART (meaningful only with bus_oe)
//   bus_oe     : tri-state enable for bus_out
//   bus_in     : io_bus value returned by the UART
// master = controller side, slave = UART side.
interface uart_ctrl_if;

   logic       sel_data;
   logic       sel_status;
   logic       rnw;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic [7:0] bus_in;

   modport master (
      output sel_data, sel_status, rnw, bus_out, bus_oe,
      input  bus_in
   );

   modport slave (
      input  sel_data, sel_status, rnw, bus_out, bus_oe,
      output bus_in
   );

endinterface

// File: rtl/uart_ctrl_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a combinational head output.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push, din  : write din when push is high and the FIFO is not full
//   pop        : discard the head when pop is high and the FIFO is not empty
//   dout       : current head entry (undefined while empty)
//   full/empty : occupancy flags, evaluated before this cycle's push/pop
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // full is taken from the registered count, so a push into a full FIFO
   // is dropped even when a pop happens on the same edge.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; the count
   // only moves when exactly one of push/pop is performed.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl
// Sequences every CPU access to the UART peripheral. CPU transmit bytes are
// queued in a small FIFO and written to the UART data port only after a
// status poll reports TX ready. CPU reads (status or RX data) take priority
// over draining but never interrupt a poll or write already under way.
//   clk, reset     : clock and synchronous active-high reset
//   cpu_wr_en/data : push a byte into the TX FIFO
//   cpu_rd_req/sel : level read request (sel 0 = status, 1 = RX data)
//   cpu_rd_data    : read result, valid with the one-cycle cpu_rd_valid
//   cpu_clr_ovf    : clears the sticky tx_overflow flag
//   tx_full/empty  : TX FIFO occupancy
//   tx_overflow    : sticky, a write was dropped because the FIFO was full
//   uart           : registered UART register bus (master side)
module uart_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int TX_READY_BIT = TX_READY,
   parameter int POLL_GAP     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cpu_wr_en,
   input  logic [7:0]   cpu_wr_data,
   input  logic         cpu_rd_req,
   input  logic         cpu_rd_sel,
   output logic [7:0]   cpu_rd_data,
   output logic         cpu_rd_valid,
   input  logic         cpu_clr_ovf,
   output logic         tx_full,
   output logic         tx_empty,
   output logic         tx_overflow,
   uart_ctrl_if.master  uart
);

   localparam int GAP_W = gap_width(POLL_GAP);

   // The IDLE cycle that sees the counter at zero is itself one of the
   // back-off cycles, so loading gap-1 yields exactly POLL_GAP idle cycles
   // between a not-ready poll and the next poll.
   localparam logic [GAP_W-1:0] GAP_LOAD =
      (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

   ctrl_state_t      state;
   logic [GAP_W-1:0] gap_q;
   logic [7:0]       fifo_head;
   logic             fifo_pop;
   logic             sel_data_q;
   logic             sel_status_q;
   logic             rnw_q;
   logic             oe_q;
   logic [7:0]       bus_out_q;

   // The FIFO head is stable from POLL through TX because only TX pops.
   assign fifo_pop = (state == ST_TX);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cpu_wr_en),
      .pop   (fifo_pop),
      .din   (cpu_wr_data),
      .dout  (fifo_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign uart.sel_data   = sel_data_q;
   assign uart.sel_status = sel_status_q;
   assign uart.rnw        = rnw_q;
   assign uart.bus_oe     = oe_q;
   assign uart.bus_out    = bus_out_q;

   // Sticky overflow flag: a dropped write wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_overflow <= 1'b0;
      end else if (cpu_wr_en && tx_full) begin
         tx_overflow <= 1'b1;
      end else if (cpu_clr_ovf) begin
         tx_overflow <= 1'b0;
      end
   end

   // Access sequencer. The bus strobes are registered: the decision made in
   // one state loads the strobes that are presented during the next state's
   // cycle, and every access lasts exactly one cycle. Anything not loaded
   // explicitly falls back to the idle bus (no select, read, no drive).
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         gap_q        <= '0;
         sel_data_q   <= 1'b0;
         sel_status_q <= 1'b0;
         rnw_q        <= 1'b1;
         oe_q         <= 1'b0;
         bus_out_q    <= 8'h00;
         cpu_rd_valid <= 1'b0;
         cpu_rd_data  <= 8'h00;
      end else begin
         sel_data_q   <= 1'b0;
         sel_status_q <= 1'b0;
         rnw_q        <= 1'b1;
         oe_q         <= 1'b0;
         bus_out_q    <= 8'h00;
         cpu_rd_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (cpu_rd_req) begin
                  state        <= ST_RD;
                  sel_data_q   <= cpu_rd_sel;
                  sel_status_q <= !cpu_rd_sel;
               end else if (!tx_empty && gap_q == '0) begin
                  state        <= ST_POLL;
                  sel_status_q <= 1'b1;
               end else if (gap_q != '0) begin
                  gap_q <= gap_q - GAP_W'(1);
               end
            end

            ST_RD: begin
               cpu_rd_data  <= uart.bus_in;
               cpu_rd_valid <= 1'b1;
               state        <= ST_IDLE;
            end

            ST_POLL: begin
               if (uart.bus_in[TX_READY_BIT]) begin
                  state      <= ST_TX;
                  sel_data_q <= 1'b1;
                  rnw_q      <= 1'b0;
                  oe_q       <= 1'b1;
                  bus_out_q  <= fifo_head;
               end else begin
                  state <= ST_IDLE;
                  gap_q <= GAP_LOAD;
               end
            end

            ST_TX: begin
               state <= ST_IDLE;
               gap_q <= '0;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl
// Directed bench for uart_ctrl. A behavioural UART answers status reads
// from a poll counter (so the number of not-ready polls is controllable) and
// data reads from rx_byte. Expected UART writes and CPU read results are
// queued when stimulus is issued; a negedge monitor pops and compares them
// whenever the DUT presents a write strobe or cpu_rd_valid.
module tb_uart_ctrl;
   import uart_ctrl_pkg::*;

   localparam int DEPTH    = 4;
   localparam int POLL_GAP = 4;
   localparam int NEVER    = 1000000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_wr_en = 1'b0;
   logic [7:0] cpu_wr_data = 8'h00;
   logic       cpu_rd_req = 1'b0;
   logic       cpu_rd_sel = 1'b0;
   logic       cpu_clr_ovf = 1'b0;
   logic [7:0] cpu_rd_data;
   logic       cpu_rd_valid;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_overflow;

   uart_ctrl_if uart_bus ();

   uart_ctrl #(
      .DEPTH        (DEPTH),
      .TX_READY_BIT (TX_READY),
      .POLL_GAP     (POLL_GAP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_wr_en    (cpu_wr_en),
      .cpu_wr_data  (cpu_wr_data),
      .cpu_rd_req   (cpu_rd_req),
      .cpu_rd_sel   (cpu_rd_sel),
      .cpu_rd_data  (cpu_rd_data),
      .cpu_rd_valid (cpu_rd_valid),
      .cpu_clr_ovf  (cpu_clr_ovf),
      .tx_full      (tx_full),
      .tx_empty     (tx_empty),
      .tx_overflow  (tx_overflow),
      .uart         (uart_bus)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle++;

   // UART model state: TX ready once poll_cnt reaches ready_from_poll.
   int         poll_cnt = 0;
   int         ready_from_poll = 0;
   logic       rx_avail = 1'b0;
   logic [7:0] rx_byte = 8'h00;

   // Scoreboard
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rd[$];
   int         poll_cycles[$];
   int         n_vec = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;

   // Status reads return the ready/avail bits; data reads return rx_byte.
   always_comb begin
      uart_bus.bus_in = 8'h00;
      if (uart_bus.sel_status) begin
         uart_bus.bus_in[TX_READY] = (poll_cnt >= ready_from_poll);
         uart_bus.bus_in[RX_AVAIL] = rx_avail;
      end else if (uart_bus.sel_data && uart_bus.rnw) begin
         uart_bus.bus_in = rx_byte;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cycle);
      end
   endtask

   // Queue an expected UART write (if the byte should be accepted) and
   // present it on the CPU write port for one cycle. Called at a negedge.
   task automatic applyStimulus(input logic [7:0] data, input bit accepted);
      if (accepted) exp_tx.push_back(data);
      cpu_wr_en   = 1'b1;
      cpu_wr_data = data;
      @(negedge clk);
      cpu_wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int limit);
      int k;
      k = 0;
      while (k < limit && !(exp_tx.size() == 0 && tx_empty === 1'b1)) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if (k >= limit) begin
         n_fail++;
         $display("[TB] FAIL %s: drain timeout, %0d writes still pending, tx_empty=%0b",
                  name, exp_tx.size(), tx_empty);
      end
      repeat (3) @(negedge clk);
   endtask

   // Advance to the next negedge showing a poll (want_tx=0) or a UART
   // write (want_tx=1).
   task automatic wait_strobe(input string name, input bit want_tx);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (want_tx) found = uart_bus.sel_data && !uart_bus.rnw;
         else         found = uart_bus.sel_status && !cpu_rd_req;
      end
      n_vec++;
      if (!found) begin
         n_fail++;
         $display("[TB] FAIL %s: strobe never seen, got none, expected one within 40 cycles",
                  name);
      end
   endtask

   // Raise a read request and count negedges until cpu_rd_valid.
   task automatic do_read(input bit sel, input logic [7:0] expected,
                          output int lat);
      bit got;
      got = 1'b0;
      exp_rd.push_back(expected);
      cpu_rd_sel = sel;
      cpu_rd_req = 1'b1;
      lat = 0;
      while (lat < 20 && !got) begin
         @(negedge clk);
         lat++;
         got = (cpu_rd_valid === 1'b1);
      end
      cpu_rd_req = 1'b0;
      if (!got) begin
         n_vec++;
         n_fail++;
         $display("[TB] FAIL rd_timeout: cpu_rd_valid got 0, expected 1 within 20 cycles");
      end
   endtask

   // Monitor: bus protocol, UART writes and CPU read completions.
   always @(negedge clk) begin
      if (mon_en) begin
         if (uart_bus.sel_data || uart_bus.sel_status)
            checkOutput("sel_exclusive", uart_bus.sel_data & uart_bus.sel_status, 0);
         if (uart_bus.bus_oe)
            checkOutput("oe_only_on_write", uart_bus.rnw, 0);
         if (uart_bus.sel_status && !(cpu_rd_req && !cpu_rd_sel)) begin
            poll_cnt++;
            poll_cycles.push_back(cycle);
         end
         if (uart_bus.sel_data && uart_bus.rnw)
            checkOutput("no_spec_data_read", cpu_rd_req && cpu_rd_sel, 1);
         if (uart_bus.sel_data && !uart_bus.rnw) begin
            checkOutput("tx_oe", uart_bus.bus_oe, 1);
            if (exp_tx.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("[TB] FAIL tx_unexpected: got write 0x%02h, expected none",
                        uart_bus.bus_out);
            end else begin
               checkOutput("tx_byte", uart_bus.bus_out, exp_tx.pop_front());
            end
         end
         if (cpu_rd_valid === 1'b1) begin
            if (exp_rd.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("[TB] FAIL rd_unexpected: got 0x%02h, expected none", cpu_rd_data);
            end else begin
               checkOutput("rd_data", cpu_rd_data, exp_rd.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int base;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_sel_data", uart_bus.sel_data, 0);
      checkOutput("rst_sel_status", uart_bus.sel_status, 0);
      checkOutput("rst_rnw", uart_bus.rnw, 1);
      checkOutput("rst_oe", uart_bus.bus_oe, 0);
      checkOutput("rst_bus_out", uart_bus.bus_out, 0);
      checkOutput("rst_tx_empty", tx_empty, 1);
      checkOutput("rst_tx_full", tx_full, 0);
      checkOutput("rst_overflow", tx_overflow, 0);
      checkOutput("rst_rd_valid", cpu_rd_valid, 0);
      checkOutput("rst_rd_data", cpu_rd_data, 0);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Two bytes, UART always ready
      $display("[TB] two writes, always ready");
      ready_from_poll = 0;
      applyStimulus(8'h41, 1'b1);
      applyStimulus(8'h42, 1'b1);
      wait_drain("drain_41_42", 100);
      checkOutput("empty_after_two", tx_empty, 1);

      // Three not-ready polls, ready on the fourth
      $display("[TB] poll back-off");
      poll_cycles.delete();
      base = poll_cnt;
      ready_from_poll = base + 4;
      applyStimulus(8'h55, 1'b1);
      wait_drain("drain_55", 100);
      checkOutput("poll_count", poll_cycles.size(), 4);
      if (poll_cycles.size() >= 4) begin
         for (int i = 1; i < 4; i++)
            checkOutput("poll_spacing", poll_cycles[i] - poll_cycles[i-1], 5);
      end

      // Overflow while UART not ready
      $display("[TB] fill and overflow");
      ready_from_poll = NEVER;
      for (int i = 0; i < 4; i++)
         applyStimulus(8'h10 + 8'(i), 1'b1);
      checkOutput("full_after_4", tx_full, 1);
      applyStimulus(8'h14, 1'b0);
      checkOutput("ovf_set", tx_overflow, 1);
      checkOutput("still_full", tx_full, 1);
      cpu_clr_ovf = 1'b1;
      applyStimulus(8'h15, 1'b0);
      cpu_clr_ovf = 1'b0;
      checkOutput("ovf_set_beats_clr", tx_overflow, 1);
      cpu_clr_ovf = 1'b1;
      @(negedge clk);
      cpu_clr_ovf = 1'b0;
      checkOutput("ovf_cleared", tx_overflow, 0);
      ready_from_poll = 0;
      wait_drain("drain_10_13", 200);
      checkOutput("ovf_stays_clear", tx_overflow, 0);

      // Push on the same edge as a TX pop with two entries queued
      $display("[TB] push during pop");
      ready_from_poll = NEVER;
      applyStimulus(8'h20, 1'b1);
      applyStimulus(8'h21, 1'b1);
      ready_from_poll = 0;
      wait_strobe("tx_of_20", 1'b1);
      ready_from_poll = NEVER;
      applyStimulus(8'h22, 1'b1);
      applyStimulus(8'h23, 1'b1);
      checkOutput("count3_not_full", tx_full, 0);
      applyStimulus(8'h24, 1'b1);
      checkOutput("count4_full", tx_full, 1);
      ready_from_poll = 0;
      wait_drain("drain_20_24", 200);

      // Data read raised during a poll
      $display("[TB] read during poll");
      rx_byte = 8'h5A;
      applyStimulus(8'h66, 1'b1);
      wait_strobe("poll_of_66", 1'b0);
      do_read(1'b1, 8'h5A, lat);
      checkOutput("rd_in_poll_within_4", lat <= 4, 1);
      wait_drain("drain_66", 100);

      // Reads from idle: exact latency
      $display("[TB] idle reads");
      rx_avail = 1'b1;
      do_read(1'b0, 8'h03, lat);
      checkOutput("status_rd_latency", lat, 2);
      rx_byte = 8'hC3;
      do_read(1'b1, 8'hC3, lat);
      checkOutput("data_rd_latency", lat, 2);
      rx_avail = 1'b0;
      @(negedge clk);

      // Reset while a write strobe is on the bus
      $display("[TB] reset during TX");
      applyStimulus(8'h30, 1'b1);
      applyStimulus(8'h31, 1'b1);
      wait_strobe("tx_of_30", 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rtx_sel_data", uart_bus.sel_data, 0);
      checkOutput("rtx_sel_status", uart_bus.sel_status, 0);
      checkOutput("rtx_rnw", uart_bus.rnw, 1);
      checkOutput("rtx_oe", uart_bus.bus_oe, 0);
      checkOutput("rtx_tx_empty", tx_empty, 1);
      checkOutput("rtx_tx_full", tx_full, 0);
      // 0x31 was still queued and is discarded by the reset.
      exp_tx.delete();
      repeat (20) @(negedge clk);
      checkOutput("rtx_quiet_empty", tx_empty, 1);
      applyStimulus(8'h32, 1'b1);
      wait_drain("drain_32", 100);

      checkOutput("rd_queue_empty", exp_rd.size(), 0);
      checkOutput("tx_queue_empty", exp_tx.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
